// File: rtl/instr_compiler_if.sv
// Interface bundling the instruction word and the classifier outputs.
// The master drives the instruction; the slave (classifier) returns IDs.
interface instr_compiler_if;
    logic [31:0] Instr;
    logic [5:0]  MIPS;
    logic [5:0]  MIPS_q;
    logic        is_RI;

    modport master (
        output Instr,
        input  MIPS,
        input  MIPS_q,
        input  is_RI
    );

    modport slave (
        input  Instr,
        output MIPS,
        output MIPS_q,
        output is_RI
    );
endinterface

// File: rtl/instr_compiler.sv
// Instruction classifier: maps a 32-bit MIPS instruction word to a 6-bit
// instruction ID (combinational) plus a one-cycle registered copy.
// Unrecognised encodings map to RI_CODE so Decode can raise a
// Reserved-Instruction exception.
module instr_compiler #(
    parameter logic [5:0] RI_CODE = 6'd63
) (
    input  logic            clk,
    input  logic            reset,
    instr_compiler_if.slave bus
);

    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic [5:0] w_mips;
    logic [5:0] r_mips_q;

    assign w_op    = bus.Instr[31:26];
    assign w_rs    = bus.Instr[25:21];
    assign w_rt    = bus.Instr[20:16];
    assign w_funct = bus.Instr[5:0];

    // Decode the instruction fields into an ID; default is reserved instruction.
    always_comb begin
        w_mips = RI_CODE;
        case (w_op)
            6'h00: begin
                // The all-zero word is NOP and must win over SLL $0,$0,0.
                if (bus.Instr == 32'h0) begin
                    w_mips = 6'd0;
                end else begin
                    case (w_funct)
                        6'h20:   w_mips = 6'd1;
                        6'h21:   w_mips = 6'd2;
                        6'h22:   w_mips = 6'd3;
                        6'h23:   w_mips = 6'd4;
                        6'h00:   w_mips = 6'd5;
                        6'h02:   w_mips = 6'd6;
                        6'h03:   w_mips = 6'd7;
                        6'h04:   w_mips = 6'd8;
                        6'h06:   w_mips = 6'd9;
                        6'h07:   w_mips = 6'd10;
                        6'h24:   w_mips = 6'd11;
                        6'h25:   w_mips = 6'd12;
                        6'h26:   w_mips = 6'd13;
                        6'h27:   w_mips = 6'd14;
                        6'h2A:   w_mips = 6'd15;
                        6'h2B:   w_mips = 6'd16;
                        6'h08:   w_mips = 6'd41;
                        6'h09:   w_mips = 6'd42;
                        6'h18:   w_mips = 6'd43;
                        6'h19:   w_mips = 6'd44;
                        6'h1A:   w_mips = 6'd45;
                        6'h1B:   w_mips = 6'd46;
                        6'h10:   w_mips = 6'd47;
                        6'h12:   w_mips = 6'd48;
                        6'h11:   w_mips = 6'd49;
                        6'h13:   w_mips = 6'd50;
                        default: w_mips = RI_CODE;
                    endcase
                end
            end
            6'h01: begin
                // REGIMM: only BLTZ/BGEZ are implemented.
                case (w_rt)
                    5'h00:   w_mips = 6'd37;
                    5'h01:   w_mips = 6'd38;
                    default: w_mips = RI_CODE;
                endcase
            end
            6'h08: w_mips = 6'd17;
            6'h09: w_mips = 6'd18;
            6'h0C: w_mips = 6'd19;
            6'h0D: w_mips = 6'd20;
            6'h0E: w_mips = 6'd21;
            6'h0F: w_mips = 6'd22;
            6'h0A: w_mips = 6'd23;
            6'h0B: w_mips = 6'd24;
            6'h20: w_mips = 6'd25;
            6'h24: w_mips = 6'd26;
            6'h21: w_mips = 6'd27;
            6'h25: w_mips = 6'd28;
            6'h23: w_mips = 6'd29;
            6'h28: w_mips = 6'd30;
            6'h29: w_mips = 6'd31;
            6'h2B: w_mips = 6'd32;
            6'h04: w_mips = 6'd33;
            6'h05: w_mips = 6'd34;
            6'h06: w_mips = 6'd35;
            6'h07: w_mips = 6'd36;
            6'h02: w_mips = 6'd39;
            6'h03: w_mips = 6'd40;
            6'h10: begin
                // COP0: ERET is recognised only as the exact canonical word.
                if (bus.Instr == ERET_WORD) begin
                    w_mips = 6'd53;
                end else begin
                    case (w_rs)
                        5'h00:   w_mips = 6'd51;
                        5'h04:   w_mips = 6'd52;
                        default: w_mips = RI_CODE;
                    endcase
                end
            end
            default: w_mips = RI_CODE;
        endcase
    end

    // Register the ID for the next stage; reset forces NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mips_q <= 6'd0;
        end else begin
            r_mips_q <= w_mips;
        end
    end

    assign bus.MIPS   = w_mips;
    assign bus.MIPS_q = r_mips_q;
    assign bus.is_RI  = (w_mips == RI_CODE);

endmodule

// File: tb/tb_instr_compiler.sv
// Table-driven bench for instr_compiler: every vector checks the
// combinational ID, the RI flag and the registered copy one edge later,
// followed by hand-written reset sequences.
module tb_instr_compiler;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    instr_compiler_if bus ();

    instr_compiler #(.RI_CODE(6'd63)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  mips;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] instr, logic [5:0] mips, string name);
        vec_t v;
        v.instr = instr;
        v.mips  = mips;
        v.name  = name;
        return v;
    endfunction

    // R-type with nonzero rs/rt/rd/shamt so only funct selects the ID.
    function automatic logic [31:0] rw(logic [5:0] funct);
        return {6'h00, 5'd9, 5'd10, 5'd11, 5'd4, funct};
    endfunction

    // Opcode-selected word with arbitrary register and immediate fields.
    function automatic logic [31:0] iw(logic [5:0] op);
        return {op, 5'd9, 5'd10, 16'h0004};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs.push_back(mk(32'h0000_0000, 6'd0,  "NOP"));
        vecs.push_back(mk(32'h0001_1080, 6'd5,  "SLL_plan"));
        vecs.push_back(mk(32'h0232_4020, 6'd1,  "ADD_plan"));
        vecs.push_back(mk(rw(6'h20), 6'd1,  "ADD"));
        vecs.push_back(mk(rw(6'h21), 6'd2,  "ADDU"));
        vecs.push_back(mk(rw(6'h22), 6'd3,  "SUB"));
        vecs.push_back(mk(rw(6'h23), 6'd4,  "SUBU"));
        vecs.push_back(mk(rw(6'h00), 6'd5,  "SLL"));
        vecs.push_back(mk(rw(6'h02), 6'd6,  "SRL"));
        vecs.push_back(mk(rw(6'h03), 6'd7,  "SRA"));
        vecs.push_back(mk(rw(6'h04), 6'd8,  "SLLV"));
        vecs.push_back(mk(rw(6'h06), 6'd9,  "SRLV"));
        vecs.push_back(mk(rw(6'h07), 6'd10, "SRAV"));
        vecs.push_back(mk(rw(6'h24), 6'd11, "AND"));
        vecs.push_back(mk(rw(6'h25), 6'd12, "OR"));
        vecs.push_back(mk(rw(6'h26), 6'd13, "XOR"));
        vecs.push_back(mk(rw(6'h27), 6'd14, "NOR"));
        vecs.push_back(mk(rw(6'h2A), 6'd15, "SLT"));
        vecs.push_back(mk(rw(6'h2B), 6'd16, "SLTU"));
        vecs.push_back(mk(iw(6'h08), 6'd17, "ADDI"));
        vecs.push_back(mk(iw(6'h09), 6'd18, "ADDIU"));
        vecs.push_back(mk(iw(6'h0C), 6'd19, "ANDI"));
        vecs.push_back(mk(iw(6'h0D), 6'd20, "ORI"));
        vecs.push_back(mk(iw(6'h0E), 6'd21, "XORI"));
        vecs.push_back(mk(iw(6'h0F), 6'd22, "LUI"));
        vecs.push_back(mk(iw(6'h0A), 6'd23, "SLTI"));
        vecs.push_back(mk(iw(6'h0B), 6'd24, "SLTIU"));
        vecs.push_back(mk(iw(6'h20), 6'd25, "LB"));
        vecs.push_back(mk(iw(6'h24), 6'd26, "LBU"));
        vecs.push_back(mk(iw(6'h21), 6'd27, "LH"));
        vecs.push_back(mk(iw(6'h25), 6'd28, "LHU"));
        vecs.push_back(mk(32'h8D09_0004, 6'd29, "LW"));
        vecs.push_back(mk(iw(6'h28), 6'd30, "SB"));
        vecs.push_back(mk(iw(6'h29), 6'd31, "SH"));
        vecs.push_back(mk(32'hAD09_0004, 6'd32, "SW"));
        vecs.push_back(mk(iw(6'h04), 6'd33, "BEQ"));
        vecs.push_back(mk(iw(6'h05), 6'd34, "BNE"));
        vecs.push_back(mk(iw(6'h06), 6'd35, "BLEZ"));
        vecs.push_back(mk(iw(6'h07), 6'd36, "BGTZ"));
        vecs.push_back(mk(32'h0520_0003, 6'd37, "BLTZ"));
        vecs.push_back(mk(32'h0401_0003, 6'd38, "BGEZ"));
        vecs.push_back(mk(32'h0402_0003, 6'd63, "REGIMM_rt2"));
        vecs.push_back(mk(iw(6'h02), 6'd39, "J"));
        vecs.push_back(mk(32'h0C00_0100, 6'd40, "JAL"));
        vecs.push_back(mk(32'h03E0_0008, 6'd41, "JR"));
        vecs.push_back(mk(rw(6'h09), 6'd42, "JALR"));
        vecs.push_back(mk(rw(6'h18), 6'd43, "MULT"));
        vecs.push_back(mk(rw(6'h19), 6'd44, "MULTU"));
        vecs.push_back(mk(rw(6'h1A), 6'd45, "DIV"));
        vecs.push_back(mk(rw(6'h1B), 6'd46, "DIVU"));
        vecs.push_back(mk(rw(6'h10), 6'd47, "MFHI"));
        vecs.push_back(mk(rw(6'h12), 6'd48, "MFLO"));
        vecs.push_back(mk(rw(6'h11), 6'd49, "MTHI"));
        vecs.push_back(mk(rw(6'h13), 6'd50, "MTLO"));
        vecs.push_back(mk(32'h4008_6000, 6'd51, "MFC0"));
        vecs.push_back(mk(32'h4088_6000, 6'd52, "MTC0"));
        vecs.push_back(mk(32'h4200_0018, 6'd53, "ERET"));
        vecs.push_back(mk(32'h4200_0019, 6'd63, "ERET_bad"));
        vecs.push_back(mk(32'h4200_0058, 6'd63, "ERET_bad2"));
        vecs.push_back(mk(32'h4028_6000, 6'd63, "COP0_rs1"));
        vecs.push_back(mk(32'hFC00_0000, 6'd63, "op3F"));
        vecs.push_back(mk(32'h0000_003F, 6'd63, "funct3F"));
        vecs.push_back(mk(rw(6'h01), 6'd63, "funct01"));
        vecs.push_back(mk(rw(6'h05), 6'd63, "funct05"));
        vecs.push_back(mk(iw(6'h11), 6'd63, "op11"));
        vecs.push_back(mk(iw(6'h22), 6'd63, "op22"));

        // Reset with a non-NOP instruction: MIPS_q held at 0, MIPS unaffected.
        reset     = 1'b1;
        bus.Instr = 32'h0232_4020;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_MIPS_q", 32'(bus.MIPS_q), 32'd0);
        chk("reset_MIPS", 32'(bus.MIPS), 32'd1);
        chk("reset_is_RI", 32'(bus.is_RI), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            bus.Instr = vecs[k].instr;
            #1;
            $display("vec %0d %s instr=%h mips=%0d is_RI=%0b", k, vecs[k].name,
                     bus.Instr, bus.MIPS, bus.is_RI);
            chk({vecs[k].name, "_MIPS"}, 32'(bus.MIPS), 32'(vecs[k].mips));
            chk({vecs[k].name, "_is_RI"}, 32'(bus.is_RI), 32'(vecs[k].mips == 6'd63));
            @(posedge clk);
            #1;
            chk({vecs[k].name, "_MIPS_q"}, 32'(bus.MIPS_q), 32'(vecs[k].mips));
        end

        // ADD then clock: registered copy follows.
        @(negedge clk);
        bus.Instr = 32'h0232_4020;
        @(posedge clk);
        #1;
        $display("seq ADD capture MIPS_q=%0d", bus.MIPS_q);
        chk("seq_add_MIPS_q", 32'(bus.MIPS_q), 32'd1);

        // Reset for one edge while LW is presented.
        @(negedge clk);
        reset     = 1'b1;
        bus.Instr = 32'h8D09_0004;
        @(posedge clk);
        #1;
        $display("seq reset LW MIPS=%0d MIPS_q=%0d", bus.MIPS, bus.MIPS_q);
        chk("seq_rst_MIPS_q", 32'(bus.MIPS_q), 32'd0);
        chk("seq_rst_MIPS", 32'(bus.MIPS), 32'd29);

        // Release reset: capture resumes on the next edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("seq_rel_hold_MIPS_q", 32'(bus.MIPS_q), 32'd0);
        @(posedge clk);
        #1;
        $display("seq release LW MIPS_q=%0d", bus.MIPS_q);
        chk("seq_rel_MIPS_q", 32'(bus.MIPS_q), 32'd29);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_compiler.md
Name: instr_compiler

Overview:
- Instruction classifier for the MIPS pipeline (P7 instruction set plus CP0/exception support).
- Maps a 32-bit instruction word to a 6-bit instruction ID, MIPS. Used in Decode to select control and to raise the Reserved-Instruction exception (ExcCode RI when MIPS == RI).
- MIPS is purely combinational. A registered copy, MIPS_q, is provided for consumers one stage later.

Parameters:
- RI_CODE, 63, ID output for any unrecognised instruction.

Ports:
- clk  input  1  clock; only MIPS_q is sequential.
- reset  input  1  synchronous, active-high reset.
- Instr  input  32  instruction word.
- MIPS  output  6  combinational instruction ID.
- MIPS_q  output  6  MIPS registered on each rising clk edge.
- is_RI  output  1  combinational; 1 when MIPS == RI_CODE.

Behaviour:
- Field definitions:
  - op = Instr[31:26]; rs = [25:21]; rt = [20:16]; funct = [5:0].
  - Fields not listed below (shamt, rd, immediates) are not checked.
- ID table (ID name op/funct, hex):
  - 0 NOP: Instr == 32'h0. This takes priority over SLL.
  - op 00 (R-type), by funct: 1 ADD 20; 2 ADDU 21; 3 SUB 22; 4 SUBU 23; 5 SLL 00; 6 SRL 02; 7 SRA 03; 8 SLLV 04; 9 SRLV 06; 10 SRAV 07; 11 AND 24; 12 OR 25; 13 XOR 26; 14 NOR 27; 15 SLT 2A; 16 SLTU 2B.
  - I-type ALU, by op: 17 ADDI 08; 18 ADDIU 09; 19 ANDI 0C; 20 ORI 0D; 21 XORI 0E; 22 LUI 0F; 23 SLTI 0A; 24 SLTIU 0B.
  - Loads, by op: 25 LB 20; 26 LBU 24; 27 LH 21; 28 LHU 25; 29 LW 23.
  - Stores, by op: 30 SB 28; 31 SH 29; 32 SW 2B.
  - Branches, by op: 33 BEQ 04; 34 BNE 05; 35 BLEZ 06; 36 BGTZ 07.
  - REGIMM (op 01), by rt: 37 BLTZ rt=00; 38 BGEZ rt=01.
  - Jumps: 39 J op 02; 40 JAL op 03; 41 JR funct 08; 42 JALR funct 09.
  - Multiply/divide, op 00 by funct: 43 MULT 18; 44 MULTU 19; 45 DIV 1A; 46 DIVU 1B; 47 MFHI 10; 48 MFLO 12; 49 MTHI 11; 50 MTLO 13.
  - COP0 (op 10): 51 MFC0 rs=00; 52 MTC0 rs=04; 53 ERET requires Instr == 32'h42000018 exactly.
- Anything else gives RI_CODE (63). This includes:
  - R-type with an unlisted funct;
  - REGIMM with rt other than 00/01;
  - COP0 with other rs values or a non-exact ERET word.
- IDs 54–62 are unused and never produced.
- Timing and reset:
  - MIPS and is_RI settle within the same cycle (zero latency).
  - MIPS_q <= MIPS on each rising clk edge.
  - When reset is high at a rising clk edge, MIPS_q <= 0 (NOP). Reset has no effect on MIPS or is_RI.
  - Reset takes priority over the capture; on deassertion, capture resumes at the next edge.
- Implementation: a single case structure without latches. All outputs are defined for X-free inputs.

Test Plan:
- Instr=32'h00000000 -> MIPS=0, is_RI=0. Instr=32'h00011080 (SLL, nonzero) -> MIPS=5.
- Instr=32'h02324020 (ADD) -> MIPS=1; 32'h8D090004 (LW) -> 29; 32'hAD090004 (SW) -> 32; 32'h0C000100 (JAL) -> 40; 32'h03E00008 (JR) -> 41.
- Instr=32'h04010003 (BGEZ) -> 38; 32'h04020003 (REGIMM rt=2) -> 63, is_RI=1.
- Instr=32'h40086000 (MFC0) -> 51; 32'h40886000 (MTC0) -> 52; 32'h42000018 (ERET) -> 53; 32'h42000019 -> 63.
- Instr=32'hFC000000 (op 3F) -> 63; 32'h0000003F (R-type funct 3F) -> 63, is_RI=1.
- Registered path:
  - Apply ADD, then clock -> MIPS_q=1.
  - Assert reset for one edge with Instr=LW -> MIPS_q=0 while MIPS=29.
  - Deassert reset -> next edge MIPS_q=29.
